// File: rtl/vga_pkg.sv
// Shared VGA timing definitions: standard timing sets and the helpers that
// turn one axis' display/porch/sync figures into totals and sync windows.
package vga_pkg;

  typedef struct packed {
    int display;
    int front;
    int sync;
    int back;
  } axis_timing_t;

  localparam axis_timing_t H_640X480 = '{640, 16, 96, 48};
  localparam axis_timing_t V_640X480 = '{480, 10,  2, 33};
  localparam axis_timing_t H_800X600 = '{800, 40, 128, 88};
  localparam axis_timing_t V_800X600 = '{600,  1,  4, 23};

  function automatic int axis_total(input int display, input int front,
                                    input int sync, input int back);
    return display + front + sync + back;
  endfunction

  // First and last coordinate of the sync window (inclusive)
  function automatic int sync_start(input int display, input int front);
    return display + front;
  endfunction

  function automatic int sync_end(input int display, input int front, input int sync);
    return display + front + sync - 1;
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Timing bundle from the sync generator to the pixel/colour stages.
interface vga_timing_gen_if #(
  parameter int CW = 11,
  parameter int FW = 8
);
  logic          p_tick;
  logic          hsync;
  logic          vsync;
  logic          video_on;
  logic [CW-1:0] x;
  logic [CW-1:0] y;
  logic          line_start;
  logic          frame_start;
  logic [FW-1:0] frame_cnt;

  modport master (
    output p_tick, hsync, vsync, video_on, x, y, line_start, frame_start, frame_cnt
  );

  modport slave (
    input  p_tick, hsync, vsync, video_on, x, y, line_start, frame_start, frame_cnt
  );
endinterface

// File: rtl/vga_axis_counter.sv
// One scan axis: position counter with wrap strobe, plus sync/active flags
// registered from the next count so they never lag the coordinate.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int DISPLAY = 640,
  parameter int FRONT   = 16,
  parameter int SYNC    = 96,
  parameter int BACK    = 48,
  parameter bit POL     = 1'b0,
  parameter int CW      = 11
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          inc,
  output logic [CW-1:0] count,
  output logic          wrap,
  output logic          sync,
  output logic          active
);

  localparam int TOTAL = axis_total(DISPLAY, FRONT, SYNC, BACK);

  if (DISPLAY < 1 || FRONT < 1 || SYNC < 1 || BACK < 1) begin : g_bad_timing
    $error("vga_axis_counter: display, porch and sync widths must be >= 1");
  end
  if (TOTAL - 1 >= (1 << CW)) begin : g_bad_cw
    $error("vga_axis_counter: CW too narrow for TOTAL-1");
  end

  localparam logic [CW-1:0] LAST    = CW'(TOTAL - 1);
  localparam logic [CW-1:0] DISP    = CW'(DISPLAY);
  localparam logic [CW-1:0] SYNC_LO = CW'(sync_start(DISPLAY, FRONT));
  localparam logic [CW-1:0] SYNC_HI = CW'(sync_end(DISPLAY, FRONT, SYNC));

  logic [CW-1:0] count_nxt;
  logic          in_sync;

  always_comb begin
    wrap      = inc && (count == LAST);
    count_nxt = count;
    if (inc) count_nxt = wrap ? '0 : count + CW'(1);
    in_sync   = (count_nxt >= SYNC_LO) && (count_nxt <= SYNC_HI);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count  <= '0;
      sync   <= ~POL;
      active <= 1'b0;
    end else begin
      count  <= count_nxt;
      sync   <= in_sync ? POL : ~POL;
      active <= (count_nxt < DISP);
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA sync generator: pixel-rate divider feeding a horizontal and
// a vertical axis counter, with registered line/frame markers and frame count.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_DISPLAY = H_640X480.display,
  parameter int H_FRONT   = H_640X480.front,
  parameter int H_SYNC    = H_640X480.sync,
  parameter int H_BACK    = H_640X480.back,
  parameter int V_DISPLAY = V_640X480.display,
  parameter int V_FRONT   = V_640X480.front,
  parameter int V_SYNC    = V_640X480.sync,
  parameter int V_BACK    = V_640X480.back,
  parameter int CLK_DIV   = 2,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0,
  parameter int CW        = 11,
  parameter int FW        = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  vga_timing_gen_if.master  vif
);

  if (CLK_DIV < 1) begin : g_bad_div
    $error("vga_timing_gen: CLK_DIV must be >= 1");
  end

  localparam int             DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0]  DIV_LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] div;
  logic          p_tick;
  logic          h_wrap, v_wrap;
  logic          h_sync, v_sync;
  logic          h_act, v_act;
  logic [CW-1:0] x, y;
  logic          line_start, frame_start;
  logic [FW-1:0] frame_cnt;

  // Gated by reset so the strobe is quiet while held in reset, even at CLK_DIV=1
  assign p_tick = reset && en && (div == DIV_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)  div <= '0;
    else if (en) div <= (div == DIV_LAST) ? '0 : div + DW'(1);
  end

  vga_axis_counter #(
    .DISPLAY (H_DISPLAY),
    .FRONT   (H_FRONT),
    .SYNC    (H_SYNC),
    .BACK    (H_BACK),
    .POL     (HSYNC_POL),
    .CW      (CW)
  ) u_h (
    .clk    (clk),
    .reset  (reset),
    .inc    (p_tick),
    .count  (x),
    .wrap   (h_wrap),
    .sync   (h_sync),
    .active (h_act)
  );

  vga_axis_counter #(
    .DISPLAY (V_DISPLAY),
    .FRONT   (V_FRONT),
    .SYNC    (V_SYNC),
    .BACK    (V_BACK),
    .POL     (VSYNC_POL),
    .CW      (CW)
  ) u_v (
    .clk    (clk),
    .reset  (reset),
    .inc    (h_wrap),
    .count  (y),
    .wrap   (v_wrap),
    .sync   (v_sync),
    .active (v_act)
  );

  // Markers load on the same edge that brings the counters back to zero
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      line_start  <= h_wrap;
      frame_start <= v_wrap;
      frame_cnt   <= frame_cnt + FW'(v_wrap);
    end
  end

  assign vif.p_tick      = p_tick;
  assign vif.hsync       = h_sync;
  assign vif.vsync       = v_sync;
  assign vif.video_on    = h_act & v_act;
  assign vif.x           = x;
  assign vif.y           = y;
  assign vif.line_start  = line_start;
  assign vif.frame_start = frame_start;
  assign vif.frame_cnt   = frame_cnt;

endmodule
